// File: rtl/bsg_blackparrot_mc_multirow_credit_link.sv
// ---------------------------------------------------------------------------
// bsg_blackparrot_mc_multirow_credit_link
//
// Purpose:
//   Bridges a BlackParrot tile's manycore endpoints to an IO router column.
//   There are num_row_p independent rows. Each row has:
//     - a forward (request) FIFO from the tile to the mesh,
//     - a reverse (response) FIFO from the mesh to the tile,
//     - an outstanding-request credit counter.
//   The credit counter stops forward issue while the mesh still owes
//   max_credits_p responses. drain_i stops new tile requests from being
//   accepted so that every row can quiesce. idle_o then reports that all
//   rows are empty and all credits have come back.
//
// Ports (all per-row buses are packed with row r at [r*W +: W]):
//   clk_i, reset_n_i                      clock, asynchronous active-low reset
//   tile_fwd_v_i / _data_i / _ready_o     tile -> fwd FIFO (ready-and)
//   mesh_fwd_v_o / _data_o / _ready_i     fwd FIFO -> router (ready-and)
//   mesh_rev_v_i / _data_i / _ready_o     router -> rev FIFO (ready-and)
//   tile_rev_v_o / _data_o / _ready_i     rev FIFO -> tile (ready-and)
//   drain_i                               block new tile fwd packets
//   credits_o                             available credits per row
//   idle_o                                all rows quiescent
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bsg_blackparrot_mc_credit_link_fifo
//
// Purpose:
//   Register-based FIFO, els_p entries (power of two). The head entry is
//   read straight out of the storage registers, so a packet is visible on
//   data_o the cycle after it is written. Pointers carry one extra wrap
//   bit so that all els_p entries are usable.
//
// Ports:
//   clk_i, reset_n_i    clock, asynchronous active-low reset
//   enq_i, data_i       write one entry (caller guarantees ~full_o)
//   deq_i               pop the head (caller guarantees ~empty_o)
//   data_o              head entry
//   full_o, empty_o     occupancy flags
// ---------------------------------------------------------------------------
module bsg_blackparrot_mc_credit_link_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]       mem_q [els_p];
  logic [width_p-1:0]       mem_d [els_p];
  logic [addr_width_lp:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width_lp:0]   rd_ptr_q, rd_ptr_d;

  // Pointer and storage update; pointers wrap naturally because els_p is a
  // power of two and the extra MSB toggles on every wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_i) begin
      mem_d[wr_ptr_q[addr_width_lp-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + (addr_width_lp+1)'(1);
    end
    if (deq_i) begin
      rd_ptr_d = rd_ptr_q + (addr_width_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[addr_width_lp] != rd_ptr_q[addr_width_lp])
                && (wr_ptr_q[addr_width_lp-1:0] == rd_ptr_q[addr_width_lp-1:0]);
  assign data_o  = mem_q[rd_ptr_q[addr_width_lp-1:0]];

endmodule

module bsg_blackparrot_mc_multirow_credit_link #(
  parameter int num_row_p     = 3,
  parameter int fwd_width_p   = 64,
  parameter int rev_width_p   = 40,
  parameter int els_p         = 4,
  parameter int max_credits_p = 16
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,

  input  logic [num_row_p-1:0]                        tile_fwd_v_i,
  input  logic [num_row_p*fwd_width_p-1:0]            tile_fwd_data_i,
  output logic [num_row_p-1:0]                        tile_fwd_ready_o,

  output logic [num_row_p-1:0]                        mesh_fwd_v_o,
  output logic [num_row_p*fwd_width_p-1:0]            mesh_fwd_data_o,
  input  logic [num_row_p-1:0]                        mesh_fwd_ready_i,

  input  logic [num_row_p-1:0]                        mesh_rev_v_i,
  input  logic [num_row_p*rev_width_p-1:0]            mesh_rev_data_i,
  output logic [num_row_p-1:0]                        mesh_rev_ready_o,

  output logic [num_row_p-1:0]                        tile_rev_v_o,
  output logic [num_row_p*rev_width_p-1:0]            tile_rev_data_o,
  input  logic [num_row_p-1:0]                        tile_rev_ready_i,

  input  logic                                        drain_i,
  output logic [num_row_p*$clog2(max_credits_p+1)-1:0] credits_o,
  output logic                                        idle_o
);

  localparam int cred_width_lp = $clog2(max_credits_p+1);
  localparam logic [cred_width_lp-1:0] cred_max_lp = cred_width_lp'(max_credits_p);

  // Out-of-reset flag. It clears asynchronously with reset and only sets on
  // the first clock edge after release, so every ready output is held low
  // throughout reset and comes up synchronously.
  logic active_q, active_d;

  assign active_d = 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  logic [num_row_p-1:0] row_idle;

  for (genvar r = 0; r < num_row_p; r++) begin : g_row

    logic                     fwd_full, fwd_empty, fwd_enq, fwd_deq;
    logic                     rev_full, rev_empty, rev_enq, rev_deq;
    logic [cred_width_lp-1:0] cred_q, cred_d;
    logic                     cred_at_max;

    // Forward path: tile -> FIFO -> mesh, gated by credits
    assign tile_fwd_ready_o[r] = active_q & ~fwd_full & ~drain_i;
    assign fwd_enq             = tile_fwd_v_i[r] & tile_fwd_ready_o[r];
    assign mesh_fwd_v_o[r]     = ~fwd_empty & (cred_q != '0);
    assign fwd_deq             = mesh_fwd_v_o[r] & mesh_fwd_ready_i[r];

    bsg_blackparrot_mc_credit_link_fifo #(
      .width_p (fwd_width_p),
      .els_p   (els_p)
    ) fwd_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .enq_i     (fwd_enq),
      .data_i    (tile_fwd_data_i[r*fwd_width_p +: fwd_width_p]),
      .deq_i     (fwd_deq),
      .data_o    (mesh_fwd_data_o[r*fwd_width_p +: fwd_width_p]),
      .full_o    (fwd_full),
      .empty_o   (fwd_empty)
    );

    // Reverse path: mesh -> FIFO -> tile, never blocked by drain
    assign mesh_rev_ready_o[r] = active_q & ~rev_full;
    assign rev_enq             = mesh_rev_v_i[r] & mesh_rev_ready_o[r];
    assign tile_rev_v_o[r]     = ~rev_empty;
    assign rev_deq             = tile_rev_v_o[r] & tile_rev_ready_i[r];

    bsg_blackparrot_mc_credit_link_fifo #(
      .width_p (rev_width_p),
      .els_p   (els_p)
    ) rev_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .enq_i     (rev_enq),
      .data_i    (mesh_rev_data_i[r*rev_width_p +: rev_width_p]),
      .deq_i     (rev_deq),
      .data_o    (tile_rev_data_o[r*rev_width_p +: rev_width_p]),
      .full_o    (rev_full),
      .empty_o   (rev_empty)
    );

    // Credits return when the response is accepted from the mesh, not when
    // the tile drains it. A response arriving with nothing outstanding is
    // an orphan; the counter saturates instead of overflowing.
    assign cred_at_max = (cred_q == cred_max_lp);

    always_comb begin
      cred_d = cred_q;
      unique case ({fwd_deq, rev_enq})
        2'b10:   cred_d = cred_q - cred_width_lp'(1);
        2'b01:   cred_d = cred_at_max ? cred_q : cred_q + cred_width_lp'(1);
        default: cred_d = cred_q;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cred_q <= cred_max_lp;
      end else begin
        cred_q <= cred_d;
      end
    end

    assign credits_o[r*cred_width_lp +: cred_width_lp] = cred_q;
    assign row_idle[r] = fwd_empty & rev_empty & cred_at_max;

    orphan_response_a: assert property (
      @(posedge clk_i) disable iff (!reset_n_i)
        !(rev_enq && !fwd_deq && cred_at_max)
    );

  end

  assign idle_o = &row_idle;

endmodule
